// File: rtl/wq_pkg.sv
// Shared definitions for the 2-bit weight quantizer/packer.
//   - 2-bit code constants (must match the decode side of the conv unit)
//   - FSM state type
//   - word geometry: 16 codes per 32-bit word
package wq_pkg;

  localparam int unsigned WORD_CODES = 16;

  localparam logic [1:0] CODE_POS = 2'b11;
  localparam logic [1:0] CODE_N1  = 2'b01;
  localparam logic [1:0] CODE_N2  = 2'b00;
  localparam logic [1:0] CODE_Z   = 2'b10;

  // Every slot preset to the zero code, so unused slots decode to 0.
  localparam logic [31:0] PAD_WORD = {WORD_CODES{CODE_Z}};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/wq_nearest.sv
// Combinational nearest-codebook-entry search.
// Ports:
//   w                       signed weight
//   pos_w, neg_w1, neg_w2   signed codebook values (zero is implicit)
//   code                    2-bit code of the nearest entry
//   exact                   weight equals the selected entry
// Ties resolve to the first entry in the order zero, pos_w, neg_w1, neg_w2.
module wq_nearest
  import wq_pkg::*;
(
  input  logic signed [7:0] w,
  input  logic signed [7:0] pos_w,
  input  logic signed [7:0] neg_w1,
  input  logic signed [7:0] neg_w2,
  output logic [1:0]        code,
  output logic              exact
);

  // 9-bit differences cannot overflow; magnitude of -255..255 fits in 9 bits.
  function automatic logic [8:0] mag9(input logic signed [8:0] d);
    return d[8] ? (~d + 9'd1) : d;
  endfunction

  logic [8:0] dist_z, dist_p, dist_n1, dist_n2, best;

  always_comb begin
    dist_z  = mag9({w[7], w});
    dist_p  = mag9({w[7], w} - {pos_w[7], pos_w});
    dist_n1 = mag9({w[7], w} - {neg_w1[7], neg_w1});
    dist_n2 = mag9({w[7], w} - {neg_w2[7], neg_w2});

    // Strict compares keep the earlier entry on a tie.
    best = dist_z;
    code = CODE_Z;
    if (dist_p < best) begin
      best = dist_p;
      code = CODE_POS;
    end
    if (dist_n1 < best) begin
      best = dist_n1;
      code = CODE_N1;
    end
    if (dist_n2 < best) begin
      best = dist_n2;
      code = CODE_N2;
    end
    exact = (best == 9'd0);
  end

endmodule

// File: rtl/wq_pack_2b.sv
// Weight encoder/packer: quantizes signed 8-bit weights to a 4-entry codebook
// {pos_w, neg_w1, neg_w2, 0} and packs 16 2-bit codes per 32-bit word.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start                       latch codebook, clear err_cnt, begin a layer
//   pos_w, neg_w1, neg_w2       codebook values, sampled on start
//   w_in, w_valid, w_ready      weight stream, w_last marks the layer's final weight
//   pk_data, pk_cnt, pk_last    packed word, number of valid codes, final-word flag
//   pk_valid, pk_ready          output handshake (single-entry output register)
//   busy                        layer in progress
//   err_cnt                     saturating count of inexactly encoded weights
// Weight i of a word lives in bits [31-2i:30-2i].
module wq_pack_2b
  import wq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [7:0]       pos_w,
  input  logic signed [7:0]       neg_w1,
  input  logic signed [7:0]       neg_w2,
  input  logic signed [7:0]       w_in,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic                    w_last,
  output logic [31:0]             pk_data,
  output logic [4:0]              pk_cnt,
  output logic                    pk_last,
  output logic                    pk_valid,
  input  logic                    pk_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        err_cnt
);

  state_e            state_q, state_d;
  logic signed [7:0] pos_q, pos_d, n1_q, n1_d, n2_q, n2_d;
  logic [31:0]       acc_q, acc_d, acc_ins;
  logic [4:0]        fill_q, fill_d;
  logic [31:0]       pk_data_q, pk_data_d;
  logic [4:0]        pk_cnt_q, pk_cnt_d;
  logic              pk_last_q, pk_last_d;
  logic              pk_valid_q, pk_valid_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic [1:0] code;
  logic       exact;
  logic       xfer;
  logic       flush;

  wq_nearest u_nearest (
    .w      (w_in),
    .pos_w  (pos_q),
    .neg_w1 (n1_q),
    .neg_w2 (n2_q),
    .code   (code),
    .exact  (exact)
  );

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    pk_data_d  = pk_data_q;
    pk_cnt_d   = pk_cnt_q;
    pk_last_d  = pk_last_q;
    pk_valid_d = pk_valid_q;
    err_d      = err_q;

    // A new weight may enter only if a resulting flush has room to land.
    w_ready = (state_q == StRun) && (!pk_valid_q || pk_ready);
    xfer    = w_valid && w_ready;
    flush   = (fill_q == 5'(WORD_CODES - 1)) || w_last;

    acc_ins = acc_q;
    for (int unsigned i = 0; i < WORD_CODES; i++) begin
      if (fill_q == 5'(i)) acc_ins[31-2*i -: 2] = code;
    end

    if (pk_valid_q && pk_ready) pk_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pos_d   = pos_w;
          n1_d    = neg_w1;
          n2_d    = neg_w2;
          err_d   = '0;
          fill_d  = '0;
          acc_d   = PAD_WORD;
        end
      end
      StRun: begin
        if (xfer) begin
          if (flush) begin
            pk_data_d  = acc_ins;
            pk_cnt_d   = fill_q + 5'd1;
            pk_last_d  = w_last;
            pk_valid_d = 1'b1;
            acc_d      = PAD_WORD;
            fill_d     = '0;
          end else begin
            acc_d  = acc_ins;
            fill_d = fill_q + 5'd1;
          end
          if (!exact && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (w_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pk_valid_q && pk_ready && pk_last_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pos_q      <= '0;
      n1_q       <= '0;
      n2_q       <= '0;
      acc_q      <= PAD_WORD;
      fill_q     <= '0;
      pk_data_q  <= '0;
      pk_cnt_q   <= '0;
      pk_last_q  <= 1'b0;
      pk_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      pk_data_q  <= pk_data_d;
      pk_cnt_q   <= pk_cnt_d;
      pk_last_q  <= pk_last_d;
      pk_valid_q <= pk_valid_d;
      err_q      <= err_d;
    end
  end

  assign pk_data  = pk_data_q;
  assign pk_cnt   = pk_cnt_q;
  assign pk_last  = pk_last_q;
  assign pk_valid = pk_valid_q;
  assign busy     = (state_q != StIdle);
  assign err_cnt  = err_q;

endmodule

// File: doc/wq_pack_2b.md
# wq_pack_2b

Weight encoder/packer for the ternary-scaled conv datapath. It takes a stream of signed 8-bit weights and quantizes each one to the nearest entry of a 4-entry codebook {pos_w, neg_w1, neg_w2, 0}. Each result becomes a 2-bit code, and 16 codes are packed into each 32-bit word for the weight SRAM. It is the write-side counterpart of the 4-lane conv unit, which decodes the same codes back into weight values.

## Interface
- CNT_W, 16, width of the inexact-encoding counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches the codebook, clears the counter and enters RUN; ignored while busy
- pos_w, neg_w1, neg_w2  in  8 each  signed codebook values, sampled on start
- w_in  in  8  signed weight
- w_valid / w_ready  in / out  1 / 1  input handshake; a transfer happens on valid && ready
- w_last  in  1  marks the final weight of the layer; qualified by the transfer
- pk_data  out  32  packed codes; weight i of the word sits in bits [31-2i:30-2i]
- pk_cnt  out  5  number of valid codes in the word, 1..16
- pk_last  out  1  word contains the final weight
- pk_valid / pk_ready  out / in  1 / 1  output handshake
- busy  out  1  state != IDLE
- err_cnt  out  CNT_W  number of weights not exactly equal to a codebook value; saturating

## Operation
- Code map: 2'b11 = pos_w, 2'b01 = neg_w1, 2'b00 = neg_w2, 2'b10 = zero.
- Quantization:
  - Per weight, compute |w_in - c| for each of the four entries using 9-bit signed differences and 9-bit magnitudes.
  - Select the minimum distance.
  - Ties go to the first entry in the order zero, pos_w, neg_w1, neg_w2.
- err_cnt increments by 1 when the minimum distance is non-zero. It holds at all-ones once saturated.
- Packing:
  - A 32-bit accumulator and a 5-bit fill count (0..16).
  - Each accepted code is written into slot fill; fill then increments.
  - The word is flushed to the output register when fill reaches 16, or when the accepted weight carries w_last.
  - Unused slots are padded with 2'b10 (zero code), so the decoded value of a padded slot is 0.
- States:
  - IDLE: w_ready=0. On start, go to RUN.
  - RUN: w_ready = !pk_valid || pk_ready. A transfer carrying w_last goes to DRAIN.
  - DRAIN: w_ready=0. When the final word is accepted (pk_valid && pk_ready && pk_last), go to IDLE.
- The output register is a single entry. pk_data, pk_cnt and pk_last hold stable while pk_valid && !pk_ready.
- A flush in the same cycle that the output register is being accepted is legal: the register reloads and pk_valid stays high.
- An empty layer (start immediately followed by no weights) is not supported; every layer carries at least one weight with w_last.
- Reset values: w_ready=0, pk_valid=0, pk_data=0, pk_cnt=0, pk_last=0, busy=0, err_cnt=0, state=IDLE, fill=0, codebook=0.
- Reset mid-operation clears everything immediately. Any partially packed word is discarded.

## Timing
- Throughput: one weight per cycle while pk_ready stays high.
- Latency: the word containing the 16th or last weight shows pk_valid=1 in the cycle after that weight's transfer.
- Backpressure: while pk_valid=1 and pk_ready=0, w_ready=0 in the same cycle (combinational). No weight is lost or duplicated.
- busy rises in the cycle after start. It falls in the cycle after the last word is accepted.
- start arriving together with w_valid in IDLE: only start takes effect. The weight is not accepted (w_ready=0).

## Structure
- Shared package (wq_pkg):
  - code constants CODE_POS=2'b11, CODE_N1=2'b01, CODE_N2=2'b00, CODE_Z=2'b10
  - state encoding IDLE/RUN/DRAIN
  - WORD_CODES=16
- Sub-module wq_nearest:
  - purely combinational
  - inputs: weight plus 3 codebook values
  - outputs: 2-bit code and an exact flag
- Top level: FSM, accumulator/fill counter, output register, err_cnt.

## Test plan
- Codebook pos=40, neg1=-20, neg2=-60; 16 weights of 40 -> one word pk_data=0xFFFFFFFF, pk_cnt=16, err_cnt=0.
- Repeating 40,-20,-60,0 ×4 with last on the 16th weight -> pk_data=0xD2D2D2D2, pk_cnt=16, pk_last=1, then IDLE.
- Weights 40,40,40 with last on the 3rd -> pk_data=0xFEAAAAAA, pk_cnt=3, pk_last=1.
- w=25 -> code 11; w=20 (tie between zero and pos) -> code 10; w=-40 (tie between neg1 and neg2) -> code 01; err_cnt=3.
- 40 weights with pk_ready held low for 5 cycles mid-stream:
  - w_ready=0 during the stall and pk_data stable
  - three words produced: 16, 16 and 8 codes
  - total accepted weights = 40
- Assert rst mid-word after 7 weights, then restart with 16 zeros -> no stale word; first word pk_data=0xAAAAAAAA.
